// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
// Opcode encodings and the propagate/generate pair used by the CLA groups.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder built from 4-bit groups.
// Group P/G feed a flat lookahead unit; no carry ripples between groups.
module cla_slice
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_carry_in,
    output logic         slice_zero
);

    localparam int NG = W / 4;

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] c;
    logic [NG:0]  gc;
    cla_pg_t      grp [NG];

    always_comb begin
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < NG; j++) begin
            grp[j].p = &p[4*j +: 4];
            grp[j].g = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
    end

    // Every group carry is its own sum of products over P/G.
    always_comb begin
        logic acc;
        logic prod;
        gc = '0;
        for (int j = 0; j <= NG; j++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc  = acc | (prod & grp[i].g);
                prod = prod & grp[i].p;
            end
            gc[j] = acc | (prod & cin);
        end
    end

    always_comb begin
        logic acc;
        logic prod;
        c = '0;
        for (int j = 0; j < NG; j++) begin
            for (int k = 0; k < 4; k++) begin
                acc  = 1'b0;
                prod = 1'b1;
                for (int i = k - 1; i >= 0; i--) begin
                    acc  = acc | (prod & g[4*j+i]);
                    prod = prod & p[4*j+i];
                end
                c[4*j+k] = acc | (prod & gc[j]);
            end
        end
    end

    assign sum          = p ^ c;
    assign cout         = gc[NG];
    assign msb_carry_in = c[W-1];
    assign slice_zero   = ~|sum;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined add/subtract unit: one CLA slice per stage, carry registered
// between stages, operands skewed forward, valid/ready on both sides.
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > 4 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_param
        $error("cla_addsub_pipe: illegal WIDTH/STAGES combination");
    end

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bp_q  [STAGES];
    logic [WIDTH-1:0]  bp_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] z_q   [STAGES];
    logic [STAGES-1:0] z_d   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic              ovf_q [STAGES];
    logic              ovf_d [STAGES];

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_bp  [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [STAGES-1:0] src_z   [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];

    logic [SW-1:0] s_a [STAGES];
    logic [SW-1:0] s_b [STAGES];
    wire  [SW-1:0] s_sum  [STAGES];
    wire           s_cout [STAGES];
    wire           s_mci  [STAGES];
    wire           s_zero [STAGES];

    logic [STAGES:0] adv;

    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    assign in_ready = rst_n && !flush && adv[0];

    // Index 0 is the incoming operation; index k is the output of stage k-1.
    always_comb begin
        src_v[0]   = in_valid && in_ready;
        src_a[0]   = in_a;
        src_bp[0]  = (in_op == OP_SUB) ? ~in_b : in_b;
        src_c[0]   = (in_op == OP_SUB) ? 1'b1 : in_cin;
        src_sum[0] = '0;
        src_z[0]   = '0;
        src_tag[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_a[k]   = a_q[k-1];
            src_bp[k]  = bp_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_z[k]   = z_q[k-1];
            src_tag[k] = tag_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_a[k] = src_a[k][k*SW +: SW];
            s_b[k] = src_bp[k][k*SW +: SW];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(
            .W (SW)
        ) u_slice (
            .a            (s_a[k]),
            .b            (s_b[k]),
            .cin          (src_c[k]),
            .sum          (s_sum[k]),
            .cout         (s_cout[k]),
            .msb_carry_in (s_mci[k]),
            .slice_zero   (s_zero[k])
        );
    end

    always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        a_d   = a_q;
        bp_d  = bp_q;
        sum_d = sum_q;
        z_d   = z_q;
        tag_d = tag_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    a_d[k]               = src_a[k];
                    bp_d[k]              = src_bp[k];
                    sum_d[k]             = src_sum[k];
                    sum_d[k][k*SW +: SW] = s_sum[k];
                    c_d[k]               = s_cout[k];
                    z_d[k]               = src_z[k];
                    z_d[k][k]            = s_zero[k];
                    tag_d[k]             = src_tag[k];
                    ovf_d[k]             = s_cout[k] ^ s_mci[k];
                end
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                sum_q[k] <= '0;
                z_q[k]   <= '0;
                tag_q[k] <= '0;
                ovf_q[k] <= 1'b0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            bp_q  <= bp_d;
            sum_q <= sum_d;
            z_q   <= z_d;
            tag_q <= tag_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];
    assign out_zero  = &z_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule
